// File: rtl/tone_arbiter_if.sv
// Button/tone bundle for tone_arbiter: raw button levels in, granted tone out.
// The master side drives the buttons; the slave side is the arbiter.
interface tone_arbiter_if;
    logic [3:0]  button;
    logic        tone_en;
    logic [17:0] tone_period;
    logic [3:0]  grant;
    logic [1:0]  active_idx;

    modport master (
        output button,
        input  tone_en, tone_period, grant, active_idx
    );

    modport slave (
        input  button,
        output tone_en, tone_period, grant, active_idx
    );
endinterface

// File: rtl/tone_arbiter.sv
// Four-button tone arbiter: synchronise, debounce, then grant one note at a time with a silent gap.
// Optional macro TONE_ARB_PREEMPT_EN lets a lower-index press take over a playing note.
module tone_arbiter #(
    parameter int          DEBOUNCE_CYCLES = 1000,
    parameter int          RELEASE_CYCLES  = 500,
    parameter logic [17:0] P0              = 18'd113636,
    parameter logic [17:0] P1              = 18'd101239,
    parameter logic [17:0] P2              = 18'd95557,
    parameter logic [17:0] P3              = 18'd85131
) (
    input  logic          clk,
    input  logic          rst_n,
    tone_arbiter_if.slave bus
);

    localparam int CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int REL_W    = $clog2(RELEASE_CYCLES + 1);
    // The IDLE arbitration cycle is part of the silent gap, so RELEASE itself is one cycle shorter.
    localparam int REL_LAST = RELEASE_CYCLES - 2;

    typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_RELEASE} state_t;

    logic [3:0]       sync1_q, sync2_q;
    logic [3:0]       deb_q, deb_d;
    logic [CNT_W-1:0] db_cnt_q [4];
    logic [CNT_W-1:0] db_cnt_d [4];
    state_t           state_q, state_d;
    logic [REL_W-1:0] rel_cnt_q, rel_cnt_d;
    logic             tone_en_q, tone_en_d;
    logic [3:0]       grant_q, grant_d;
    logic [1:0]       idx_q, idx_d;
    logic [17:0]      period_q, period_d;
    logic             preempt;

    function automatic logic [1:0] lowest_idx(input logic [3:0] v);
        lowest_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) lowest_idx = 2'(i);
        end
    endfunction

    function automatic logic [17:0] period_of(input logic [1:0] idx);
        case (idx)
            2'd0:    period_of = P0;
            2'd1:    period_of = P1;
            2'd2:    period_of = P2;
            default: period_of = P3;
        endcase
    endfunction

    // NOTE: every signal driven from always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES)) deb_d[i] = sync2_q[i];
                else                                       db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
            end
        end
    end

`ifdef TONE_ARB_PREEMPT_EN
    logic [3:0] lower_mask;
    always_comb begin
        lower_mask = (4'd1 << idx_q) - 4'd1;
        preempt    = |(deb_q & lower_mask);
    end
`else
    assign preempt = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (|deb_q) state_d = ST_PLAY;
            ST_PLAY:    if (!preempt && !deb_q[idx_q]) state_d = ST_RELEASE;
            ST_RELEASE: if (rel_cnt_q == REL_W'(REL_LAST)) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Registered outputs are computed here and loaded on the same edge as the state change.
    always_comb begin
        tone_en_d = tone_en_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        period_d  = period_q;
        rel_cnt_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (|deb_q) begin
                    tone_en_d = 1'b1;
                    idx_d     = lowest_idx(deb_q);
                    grant_d   = 4'd1 << lowest_idx(deb_q);
                    period_d  = period_of(lowest_idx(deb_q));
                end
            end
            ST_PLAY: begin
                if (preempt) begin
                    idx_d    = lowest_idx(deb_q);
                    grant_d  = 4'd1 << lowest_idx(deb_q);
                    period_d = period_of(lowest_idx(deb_q));
                end else if (!deb_q[idx_q]) begin
                    tone_en_d = 1'b0;
                    grant_d   = 4'd0;
                end
            end
            ST_RELEASE: rel_cnt_d = rel_cnt_q + REL_W'(1);
            default: begin
                tone_en_d = 1'b0;
                grant_d   = 4'd0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
            state_q   <= ST_IDLE;
            rel_cnt_q <= '0;
            tone_en_q <= 1'b0;
            grant_q   <= '0;
            idx_q     <= '0;
            period_q  <= '0;
        end else begin
            sync1_q   <= bus.button;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
            state_q   <= state_d;
            rel_cnt_q <= rel_cnt_d;
            tone_en_q <= tone_en_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            period_q  <= period_d;
        end
    end

    assign bus.tone_en     = tone_en_q;
    assign bus.grant       = grant_q;
    assign bus.active_idx  = idx_q;
    assign bus.tone_period = period_q;

endmodule

// File: tb/tb_tone_arbiter.sv
// Scoreboard bench for tone_arbiter (DEBOUNCE_CYCLES=8, RELEASE_CYCLES=4); honours TONE_ARB_PREEMPT_EN.
module tb_tone_arbiter;

    localparam int LAT = 8 + 3;

    typedef struct {
        int unsigned edge_n;
        logic        en;
        logic [3:0]  gnt;
        logic [1:0]  idx;
        logic [17:0] per;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int unsigned edge_cnt = 0;
    int n_checks = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;
    exp_t sb[$];

    tone_arbiter_if bus ();

    tone_arbiter #(.DEBOUNCE_CYCLES(8), .RELEASE_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic push(input int unsigned e, input logic en, input logic [3:0] g,
                        input logic [1:0] i, input logic [17:0] p);
        exp_t x;
        x.edge_n = e; x.en = en; x.gnt = g; x.idx = i; x.per = p;
        sb.push_back(x);
    endtask

    // Change buttons on a falling edge; the next rising edge is the first to sample them.
    task automatic set_btn(input logic [3:0] v);
        @(negedge clk);
        bus.button = v;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every output change pops one expected entry, including its edge number.
    initial begin
        logic [24:0] cur, last;
        exp_t x;
        last = '0;
        wait (mon_en);
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) #1;
            cur = {bus.tone_en, bus.grant, bus.active_idx, bus.tone_period};
            check("grant_onehot0", 32'($countones(bus.grant) <= 1), 32'd1);
            check("tone_en_eq_or_grant", 32'(bus.tone_en), 32'(|bus.grant));
            if (cur !== last) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_change: got en=%0d grant=%b idx=%0d period=%0d, expected no change (edge %0d)",
                             bus.tone_en, bus.grant, bus.active_idx, bus.tone_period, edge_cnt);
                end else begin
                    x = sb.pop_front();
                    check("edge", edge_cnt, x.edge_n);
                    check("tone_en", 32'(bus.tone_en), 32'(x.en));
                    check("grant", 32'(bus.grant), 32'(x.gnt));
                    check("active_idx", 32'(bus.active_idx), 32'(x.idx));
                    check("tone_period", 32'(bus.tone_period), 32'(x.per));
                end
                last = cur;
            end
        end
    end

    initial begin
        bus.button = 4'b0000;
        #3;
        check("rst_tone_en", 32'(bus.tone_en), 32'd0);
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_active_idx", 32'(bus.active_idx), 32'd0);
        check("rst_tone_period", 32'(bus.tone_period), 32'd0);
        idle(2);
        mon_en = 1'b1;

        // Single press right out of reset.
        @(negedge clk);
        rst_n = 1'b1;
        bus.button = 4'b0001;
        push(edge_cnt + 1 + LAT, 1'b1, 4'b0001, 2'd0, 18'd113636);
        idle(20);
        set_btn(4'b0000);
        push(edge_cnt + 1 + LAT, 1'b0, 4'b0000, 2'd0, 18'd113636);
        idle(20);

        // Bouncing button never settles long enough.
        for (int i = 0; i < 14; i++) begin
            set_btn(bus.button ^ 4'b0010);
            idle(2);
        end
        idle(20);

        // Simultaneous presses: lowest index wins.
        set_btn(4'b1010);
        push(edge_cnt + 1 + LAT, 1'b1, 4'b0010, 2'd1, 18'd101239);
        idle(20);
        set_btn(4'b0000);
        push(edge_cnt + 1 + LAT, 1'b0, 4'b0000, 2'd1, 18'd101239);
        idle(20);

        // Hold button 2, press button 0, release button 2.
        set_btn(4'b0100);
        push(edge_cnt + 1 + LAT, 1'b1, 4'b0100, 2'd2, 18'd95557);
        idle(15);
        set_btn(4'b0101);
`ifdef TONE_ARB_PREEMPT_EN
        push(edge_cnt + 1 + LAT, 1'b1, 4'b0001, 2'd0, 18'd113636);
        idle(15);
        set_btn(4'b0001);
        idle(25);
`else
        idle(15);
        set_btn(4'b0001);
        push(edge_cnt + 1 + LAT, 1'b0, 4'b0000, 2'd2, 18'd95557);
        push(edge_cnt + 1 + LAT + 4, 1'b1, 4'b0001, 2'd0, 18'd113636);
        idle(25);
`endif
        set_btn(4'b0000);
        push(edge_cnt + 1 + LAT, 1'b0, 4'b0000, 2'd0, 18'd113636);
        idle(20);

        // Asynchronous reset in the middle of a note, button 3 kept held.
        set_btn(4'b1000);
        push(edge_cnt + 1 + LAT, 1'b1, 4'b1000, 2'd3, 18'd85131);
        idle(15);
        @(posedge clk);
        #2;
        push(edge_cnt, 1'b0, 4'b0000, 2'd0, 18'd0);
        rst_n = 1'b0;
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        push(edge_cnt + 1 + LAT, 1'b1, 4'b1000, 2'd3, 18'd85131);
        idle(20);
        set_btn(4'b0000);
        push(edge_cnt + 1 + LAT, 1'b0, 4'b0000, 2'd3, 18'd85131);
        idle(20);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
